// File: rtl/mlp_ctrl_pkg.sv
// Shared types and helpers for the MLP layer control slice.
// Imported by the sequencer and its counters.
package mlp_ctrl_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    BIAS,
    MAC,
    DRAIN,
    ACT,
    WRITE,
    DONE
  } state_e;

  function automatic int clog2w(input int x);
    return (x > 2) ? $clog2(x) : 1;
  endfunction

endpackage

// File: rtl/mlp_wrap_counter.sv
// Up-counter that wraps to zero on its terminal value.
// clr has priority over en.
module mlp_wrap_counter
  import mlp_ctrl_pkg::*;
#(
  parameter int MAX = 4,
  localparam int W = clog2w(MAX)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] count,
  output logic         last
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign count = cnt_q;
  assign last  = (cnt_q == W'(MAX - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = last ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mlp_layer_sequencer.sv
// Control FSM sharing one MAC/activation datapath across all neurons
// of a layer; emits addresses, strobes and a layer_end level.
module mlp_layer_sequencer
  import mlp_ctrl_pkg::*;
#(
  parameter int N_NEURONS = 4,
  parameter int N_INPUTS  = 6,
  parameter int MAC_LAT   = 2,
  localparam int N_WEIGHTS = N_NEURONS * N_INPUTS,
  localparam int WW = clog2w(N_WEIGHTS),
  localparam int NW = clog2w(N_NEURONS),
  localparam int IW = clog2w(N_INPUTS),
  localparam int DL = (MAC_LAT < 1) ? 1 : MAC_LAT,
  localparam int DW = clog2w(DL)
) (
  input  logic          CLK,
  input  logic          reset,
  input  logic          start,
  input  logic          out_ready,
  output logic          busy,
  output logic          done,
  output logic          layer_end,
  output logic [WW-1:0] w_addr,
  output logic [NW-1:0] b_addr,
  output logic [IW-1:0] x_idx,
  output logic          mac_clear,
  output logic          mac_en,
  output logic          act_en,
  output logic          out_we,
  output logic [NW-1:0] out_idx
);

  state_e state_q, state_d;
  logic   layer_end_q, layer_end_d;

  logic [WW-1:0] w_hold_q, w_hold_d;
  logic [IW-1:0] x_hold_q, x_hold_d;
  logic [NW-1:0] b_hold_q, b_hold_d;
  logic [NW-1:0] o_hold_q, o_hold_d;

  logic [NW-1:0] n_cnt;
  logic [IW-1:0] i_cnt;
  logic [DW-1:0] d_cnt;
  logic          n_last, i_last, d_last;
  logic          accept;
  logic          d_unused;
  logic [WW-1:0] w_live;

  assign accept   = (state_q == IDLE) && start;
  assign d_unused = ^d_cnt;
  assign w_live   = WW'(n_cnt) * WW'(N_INPUTS) + WW'(i_cnt);

  mlp_wrap_counter #(.MAX(N_NEURONS)) u_n_cnt (
    .clk   (CLK),
    .rst_n (reset),
    .en    ((state_q == WRITE) && out_ready),
    .clr   (accept),
    .count (n_cnt),
    .last  (n_last)
  );

  mlp_wrap_counter #(.MAX(N_INPUTS)) u_i_cnt (
    .clk   (CLK),
    .rst_n (reset),
    .en    (state_q == MAC),
    .clr   (accept),
    .count (i_cnt),
    .last  (i_last)
  );

  mlp_wrap_counter #(.MAX(DL)) u_d_cnt (
    .clk   (CLK),
    .rst_n (reset),
    .en    (state_q == DRAIN),
    .clr   (accept),
    .count (d_cnt),
    .last  (d_last)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (start) state_d = BIAS;
      BIAS:  state_d = MAC;
      MAC: begin
        if (i_last) state_d = (MAC_LAT == 0) ? ACT : DRAIN;
      end
      DRAIN: if (d_last) state_d = ACT;
      ACT:   state_d = WRITE;
      WRITE: begin
        if (out_ready) state_d = n_last ? DONE : BIAS;
      end
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // layer_end rises together with the done pulse and holds until re-armed
  always_comb begin
    layer_end_d = layer_end_q;
    if (accept) layer_end_d = 1'b0;
    if (state_d == DONE) layer_end_d = 1'b1;
  end

  always_comb begin
    w_hold_d = w_hold_q;
    x_hold_d = x_hold_q;
    b_hold_d = b_hold_q;
    o_hold_d = o_hold_q;
    if (state_q == MAC) begin
      w_hold_d = w_live;
      x_hold_d = i_cnt;
    end
    if (state_q == BIAS) b_hold_d = n_cnt;
    if (state_q == WRITE) o_hold_d = n_cnt;
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      layer_end_q <= 1'b0;
      w_hold_q    <= '0;
      x_hold_q    <= '0;
      b_hold_q    <= '0;
      o_hold_q    <= '0;
    end else begin
      state_q     <= state_d;
      layer_end_q <= layer_end_d;
      w_hold_q    <= w_hold_d;
      x_hold_q    <= x_hold_d;
      b_hold_q    <= b_hold_d;
      o_hold_q    <= o_hold_d;
    end
  end

  assign busy      = (state_q != IDLE) && (state_q != DONE);
  assign done      = (state_q == DONE);
  assign layer_end = layer_end_q;
  assign mac_clear = (state_q == BIAS);
  assign mac_en    = (state_q == MAC);
  assign act_en    = (state_q == ACT);
  assign out_we    = (state_q == WRITE) && out_ready;

  // live indices while in use, last used value otherwise
  assign w_addr  = mac_en ? w_live : w_hold_q;
  assign x_idx   = mac_en ? i_cnt : x_hold_q;
  assign b_addr  = mac_clear ? n_cnt : b_hold_q;
  assign out_idx = (state_q == WRITE) ? n_cnt : o_hold_q;

endmodule

// File: tb/tb_mlp_layer_sequencer.sv
// Scoreboard bench for mlp_layer_sequencer plus a parameter sweep
// and a two-layer chain.
module tb_mlp_layer_sequencer;

  localparam int NN = 4;
  localparam int NI = 6;
  localparam int ML = 2;

  typedef struct {
    int k;
    int a;
    int b;
    int c;
  } ev_t;

  logic CLK = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic s_start = 1'b0;
  logic out_ready;
  int   cyc = 0;
  int   stall_from = 0;
  int   stall_len = 0;
  int   checks = 0;
  int   errs = 0;
  int   we_cnt = 0;
  int   done_cnt = 0;
  ev_t  q[$];

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  assign out_ready = !(cyc >= stall_from && cyc < stall_from + stall_len);

  logic       busy, done, layer_end, mac_clear, mac_en, act_en, out_we;
  logic [4:0] w_addr;
  logic [1:0] b_addr, out_idx;
  logic [2:0] x_idx;

  mlp_layer_sequencer dut (
    .CLK(CLK), .reset(reset), .start(start), .out_ready(out_ready),
    .busy(busy), .done(done), .layer_end(layer_end),
    .w_addr(w_addr), .b_addr(b_addr), .x_idx(x_idx),
    .mac_clear(mac_clear), .mac_en(mac_en), .act_en(act_en),
    .out_we(out_we), .out_idx(out_idx)
  );

  logic       d1_busy, d1_done, d1_le, d1_clr, d1_mac, d1_act, d1_we;
  logic [0:0] d1_w, d1_b, d1_x, d1_o;
  mlp_layer_sequencer #(.N_NEURONS(1), .N_INPUTS(1), .MAC_LAT(0)) d1 (
    .CLK(CLK), .reset(reset), .start(s_start), .out_ready(1'b1),
    .busy(d1_busy), .done(d1_done), .layer_end(d1_le),
    .w_addr(d1_w), .b_addr(d1_b), .x_idx(d1_x),
    .mac_clear(d1_clr), .mac_en(d1_mac), .act_en(d1_act),
    .out_we(d1_we), .out_idx(d1_o)
  );

  logic       d2_busy, d2_done, d2_le, d2_clr, d2_mac, d2_act, d2_we;
  logic [3:0] d2_w;
  logic [0:0] d2_b, d2_o;
  logic [2:0] d2_x;
  mlp_layer_sequencer #(.N_NEURONS(2), .N_INPUTS(8), .MAC_LAT(3)) d2 (
    .CLK(CLK), .reset(reset), .start(s_start), .out_ready(1'b1),
    .busy(d2_busy), .done(d2_done), .layer_end(d2_le),
    .w_addr(d2_w), .b_addr(d2_b), .x_idx(d2_x),
    .mac_clear(d2_clr), .mac_en(d2_mac), .act_en(d2_act),
    .out_we(d2_we), .out_idx(d2_o)
  );

  logic       a_busy, a_done, a_le, a_clr, a_mac, a_act, a_we;
  logic [4:0] a_w;
  logic [1:0] a_b, a_o;
  logic [2:0] a_x;
  mlp_layer_sequencer a_l (
    .CLK(CLK), .reset(reset), .start(s_start), .out_ready(1'b1),
    .busy(a_busy), .done(a_done), .layer_end(a_le),
    .w_addr(a_w), .b_addr(a_b), .x_idx(a_x),
    .mac_clear(a_clr), .mac_en(a_mac), .act_en(a_act),
    .out_we(a_we), .out_idx(a_o)
  );

  logic       b_busy, b_done, b_le, b_clr, b_mac, b_act, b_we;
  logic [2:0] b_w;
  logic [0:0] b_b, b_o;
  logic [1:0] b_x;
  mlp_layer_sequencer #(.N_NEURONS(2), .N_INPUTS(4), .MAC_LAT(2)) b_l (
    .CLK(CLK), .reset(reset), .start(a_le), .out_ready(1'b1),
    .busy(b_busy), .done(b_done), .layer_end(b_le),
    .w_addr(b_w), .b_addr(b_b), .x_idx(b_x),
    .mac_clear(b_clr), .mac_en(b_mac), .act_en(b_act),
    .out_we(b_we), .out_idx(b_o)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic take(input int k, input int a, input int b);
    ev_t e;
    if (q.size() == 0) begin
      chk("unexpected_event_kind", k, -1);
      return;
    end
    e = q.pop_front();
    chk("ev_kind", k, e.k);
    chk("ev_cycle", cyc, e.c);
    chk("ev_addr", a, e.a);
    chk("ev_idx", b, e.b);
  endtask

  always @(negedge CLK) begin
    if (reset) begin
      chk("onehot", int'($countones({mac_clear, mac_en, act_en, out_we}) <= 1), 1);
      if (mac_clear) take(0, int'(b_addr), 0);
      if (mac_en) take(1, int'(w_addr), int'(x_idx));
      if (act_en) take(4, 0, 0);
      if (out_we) begin
        take(2, int'(out_idx), 0);
        we_cnt++;
      end
      if (done) begin
        take(3, 0, 0);
        done_cnt++;
        chk("le_with_done", int'(layer_end), 1);
      end
    end
  end

  int d1_c = -1, d2_c = -1, a_c = -1, b_c = -1;
  int v1 = 0, v2 = 0, vb = 0;

  always @(negedge CLK) begin
    if (reset) begin
      if (d1_done && d1_c < 0) d1_c = cyc;
      if (d2_done && d2_c < 0) d2_c = cyc;
      if (a_done && a_c < 0) a_c = cyc;
      if (b_done && b_c < 0) b_c = cyc;
      if ($countones({d1_clr, d1_mac, d1_act, d1_we}) > 1) v1++;
      if (d1_mac && int'(d1_w) >= 1) v1++;
      if ($countones({d2_clr, d2_mac, d2_act, d2_we}) > 1) v2++;
      if (d2_mac && int'(d2_w) >= 16) v2++;
      if ($countones({b_clr, b_mac, b_act, b_we}) > 1) vb++;
      if (b_mac && int'(b_w) >= 8) vb++;
    end
  end

  task automatic gen(input int t0, input int sl);
    int t;
    t = t0 + 1;
    for (int n = 0; n < NN; n++) begin
      q.push_back('{0, n, 0, t});
      t++;
      for (int i = 0; i < NI; i++) begin
        q.push_back('{1, n * NI + i, i, t});
        t++;
      end
      t += ML;
      q.push_back('{4, 0, 0, t});
      t++;
      if (n == 0) t += sl;
      q.push_back('{2, n, 0, t});
      t++;
    end
    q.push_back('{3, 0, 0, t});
  endtask

  task automatic pulse(output int t0);
    @(posedge CLK);
    #1;
    start = 1'b1;
    t0 = cyc;
    @(posedge CLK);
    #1;
    start = 1'b0;
  endtask

  task automatic drain_q();
    for (int k = 0; k < 300 && q.size() != 0; k++) @(posedge CLK);
    chk("queue_empty", q.size(), 0);
    repeat (3) @(posedge CLK);
    #1;
  endtask

  task automatic wait_cyc(input int c);
    for (int k = 0; k < 300 && cyc < c; k++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_le"}, int'(layer_end), 0);
    chk({tag, "_strobes"}, int'({mac_clear, mac_en, act_en, out_we}), 0);
    chk({tag, "_waddr"}, int'(w_addr), 0);
    chk({tag, "_baddr"}, int'(b_addr), 0);
    chk({tag, "_xidx"}, int'(x_idx), 0);
    chk({tag, "_oidx"}, int'(out_idx), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int t0;
    int s0;
    #2 reset = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk_zero("reset");
    reset = 1'b1;

    pulse(t0);
    gen(t0, 0);
    drain_q();
    chk("run1_we_cnt", we_cnt, 4);
    chk("run1_done_cnt", done_cnt, 1);
    chk("run1_le_after", int'(layer_end), 1);
    chk("run1_busy_after", int'(busy), 0);

    we_cnt = 0;
    done_cnt = 0;
    pulse(t0);
    chk("le_cleared_on_start", int'(layer_end), 0);
    stall_from = t0 + 11;
    stall_len = 5;
    gen(t0, 5);
    wait_cyc(t0 + 13);
    chk("stall_busy", int'(busy), 1);
    chk("stall_we", int'(out_we), 0);
    drain_q();
    stall_len = 0;
    chk("bp_we_cnt", we_cnt, 4);

    we_cnt = 0;
    done_cnt = 0;
    pulse(t0);
    gen(t0, 0);
    wait_cyc(t0 + 26);
    start = 1'b1;
    @(posedge CLK);
    #1;
    start = 1'b0;
    drain_q();
    chk("busy_start_we_cnt", we_cnt, 4);
    chk("busy_start_done_cnt", done_cnt, 1);

    pulse(t0);
    gen(t0, 0);
    wait_cyc(t0 + 19);
    #2;
    reset = 1'b0;
    #1;
    chk_zero("abort");
    q.delete();
    @(posedge CLK);
    #1;
    reset = 1'b1;
    we_cnt = 0;
    done_cnt = 0;
    pulse(t0);
    gen(t0, 0);
    drain_q();
    chk("rerun_we_cnt", we_cnt, 4);
    chk("rerun_done_cnt", done_cnt, 1);

    @(posedge CLK);
    #1;
    s_start = 1'b1;
    s0 = cyc;
    @(posedge CLK);
    #1;
    s_start = 1'b0;
    for (int k = 0; k < 150 && b_c < 0; k++) @(posedge CLK);
    chk("sweep1_done_cycle", d1_c - s0, 1 * (1 + 0 + 3) + 1);
    chk("sweep2_done_cycle", d2_c - s0, 2 * (8 + 3 + 3) + 1);
    chk("chainA_done_cycle", a_c - s0, NN * (NI + ML + 3) + 1);
    chk("chainB_done_cycle", b_c - a_c, 2 * (4 + 2 + 3) + 1);
    chk("sweep1_viol", v1, 0);
    chk("sweep2_viol", v2, 0);
    chk("chainB_viol", vb, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errs);
    $finish;
  end

endmodule
